// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS-lite types, field slices and decode helpers
package mips_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int RAW   = 5;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [5:0] {
        OP_ADD  = 6'h00, OP_ADDI = 6'h01, OP_SUB  = 6'h02, OP_SUBI = 6'h03,
        OP_MUL  = 6'h04, OP_MULI = 6'h05, OP_OR   = 6'h06, OP_ORI  = 6'h07,
        OP_AND  = 6'h08, OP_ANDI = 6'h09, OP_XOR  = 6'h0A, OP_XORI = 6'h0B,
        OP_LDW  = 6'h0C, OP_STW  = 6'h0D, OP_BZ   = 6'h0E, OP_BEQ  = 6'h0F,
        OP_JR   = 6'h10, OP_HALT = 6'h11
    } opcode_e;

    typedef struct packed {
        logic [5:0]      op;
        logic [XLEN-1:0] rs;
        logic [XLEN-1:0] rt;
        logic [XLEN-1:0] imm;
        logic [RAW-1:0]  dest;
        logic            wr_en;
        logic            valid;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } id_ex_t;

    function automatic logic is_defined(input logic [5:0] op);
        return op <= OP_HALT;
    endfunction

    // R-type ALU ops are the even opcodes up to XOR
    function automatic logic is_rtype(input logic [5:0] op);
        return (op <= OP_XOR) && !op[0];
    endfunction

    // ALU ops (both forms) and LDW produce a register result
    function automatic logic writes_dest(input logic [5:0] op);
        return op <= OP_LDW;
    endfunction

    function automatic logic uses_rs(input logic [5:0] op);
        return op <= OP_JR;
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return is_rtype(op) || (op == OP_STW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// rtl/id_stage_regfile.sv - 32x32 register file, 2 read / 1 write, WB bypass
module regfile
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [RAW-1:0]  ra1,
    input  logic [RAW-1:0]  ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [RAW-1:0]  wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs [NREGS];

    // Write port; R0 is never written so it stays zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    // Read ports with same-cycle bypass of the WB write
    always_comb begin
        rd1 = regs[ra1];
        rd2 = regs[ra2];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (we && (wa == ra1)) begin
            rd1 = wd;
        end
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (we && (wa == ra2)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: register read, RAW scoreboard, ID/EX register
module id_stage
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] i_data,
    input  logic [XLEN-1:0] pc4_in,
    input  logic            if_valid,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [RAW-1:0]  wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_stall,
    output logic [5:0]      op,
    output logic [XLEN-1:0] rs,
    output logic [XLEN-1:0] rt,
    output logic [XLEN-1:0] imm,
    output logic [RAW-1:0]  dest_2_ex,
    output logic            wr_en_2_ex,
    output logic            valid_2_ex,
    output logic [XLEN-1:0] pc4_out_2_ex,
    output logic [XLEN-1:0] i_data_2_ex,
    output logic            halted
);

    logic [5:0]      f_op;
    logic [RAW-1:0]  f_rs;
    logic [RAW-1:0]  f_rt;
    logic [RAW-1:0]  f_rd;
    logic [15:0]     f_imm;
    logic [XLEN-1:0] rd_rs;
    logic [XLEN-1:0] rd_rt;

    logic            dec_wr;
    logic [RAW-1:0]  dec_dest;
    logic            hit_rs;
    logic            hit_rt;
    logic            hazard;
    logic            do_issue;

    logic            sb_ex_v;
    logic [RAW-1:0]  sb_ex_addr;
    logic            sb_mem_v;
    logic [RAW-1:0]  sb_mem_addr;

    id_ex_t          id_ex_d;
    id_ex_t          id_ex_q;

    assign f_op  = i_data[OP_HI:OP_LO];
    assign f_rs  = i_data[RS_HI:RS_LO];
    assign f_rt  = i_data[RT_HI:RT_LO];
    assign f_rd  = i_data[RD_HI:RD_LO];
    assign f_imm = i_data[IMM_HI:IMM_LO];

    regfile u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (f_rs),
        .ra2 (f_rt),
        .rd1 (rd_rs),
        .rd2 (rd_rt),
        .we  (wb_we),
        .wa  (wb_addr),
        .wd  (wb_data)
    );

    // Destination decode; a result aimed at R0 is not a write at all
    always_comb begin
        dec_wr   = 1'b0;
        dec_dest = '0;
        if (writes_dest(f_op)) begin
            dec_dest = is_rtype(f_op) ? f_rd : f_rt;
            dec_wr   = (dec_dest != '0);
        end
        if (!dec_wr) begin
            dec_dest = '0;
        end
    end

    // RAW check of the needed sources against producers still in EX or MEM
    always_comb begin
        hit_rs = (f_rs != '0) && ((sb_ex_v && (sb_ex_addr == f_rs)) ||
                                  (sb_mem_v && (sb_mem_addr == f_rs)));
        hit_rt = (f_rt != '0) && ((sb_ex_v && (sb_ex_addr == f_rt)) ||
                                  (sb_mem_v && (sb_mem_addr == f_rt)));
        hazard = (uses_rs(f_op) && hit_rs) || (uses_rt(f_op) && hit_rt);
    end

    // Once halted IF is frozen for good; flush beats any hazard
    assign id_stall = halted | (if_valid & ~flush & hazard);
    assign do_issue = if_valid & ~flush & ~halted & ~hazard & is_defined(f_op);

    // Next ID/EX bundle: a real instruction or an all-zero bubble
    always_comb begin
        id_ex_d = '0;
        if (do_issue) begin
            id_ex_d.op    = f_op;
            id_ex_d.rs    = rd_rs;
            id_ex_d.rt    = rd_rt;
            id_ex_d.imm   = {{(XLEN-16){f_imm[15]}}, f_imm};
            id_ex_d.dest  = dec_dest;
            id_ex_d.wr_en = dec_wr;
            id_ex_d.valid = 1'b1;
            id_ex_d.pc4   = pc4_in;
            id_ex_d.instr = i_data;
        end
    end

    // ID/EX pipeline register, no downstream hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    // Scoreboard shifts every cycle, including stall and flush cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_ex_v     <= 1'b0;
            sb_ex_addr  <= '0;
            sb_mem_v    <= 1'b0;
            sb_mem_addr <= '0;
        end else begin
            sb_ex_v     <= id_ex_d.wr_en;
            sb_ex_addr  <= id_ex_d.dest;
            sb_mem_v    <= sb_ex_v;
            sb_mem_addr <= sb_ex_addr;
        end
    end

    // Sticky halt, set as HALT leaves for EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (do_issue && (f_op == OP_HALT)) begin
            halted <= 1'b1;
        end
    end

    assign op           = id_ex_q.op;
    assign rs           = id_ex_q.rs;
    assign rt           = id_ex_q.rt;
    assign imm          = id_ex_q.imm;
    assign dest_2_ex    = id_ex_q.dest;
    assign wr_en_2_ex   = id_ex_q.wr_en;
    assign valid_2_ex   = id_ex_q.valid;
    assign pc4_out_2_ex = id_ex_q.pc4;
    assign i_data_2_ex  = id_ex_q.instr;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage against a pipeline model
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_data;
    logic [31:0] pc4_in;
    logic        if_valid;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        id_stall;
    logic [5:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  dest_2_ex;
    logic        wr_en_2_ex;
    logic        valid_2_ex;
    logic [31:0] pc4_out_2_ex;
    logic [31:0] i_data_2_ex;
    logic        halted;

    always #5 clk = ~clk;

    id_stage dut (
        .clk          (clk),
        .rst          (rst),
        .i_data       (i_data),
        .pc4_in       (pc4_in),
        .if_valid     (if_valid),
        .flush        (flush),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .id_stall     (id_stall),
        .op           (op),
        .rs           (rs),
        .rt           (rt),
        .imm          (imm),
        .dest_2_ex    (dest_2_ex),
        .wr_en_2_ex   (wr_en_2_ex),
        .valid_2_ex   (valid_2_ex),
        .pc4_out_2_ex (pc4_out_2_ex),
        .i_data_2_ex  (i_data_2_ex),
        .halted       (halted)
    );

    // Model of the rest of the pipeline: one record per issue slot,
    // newest first; entry 2 is the instruction now in WB.
    typedef struct {
        logic        wr;
        logic [4:0]  dest;
        logic [31:0] data;
    } rec_t;

    rec_t        pipe[$];
    logic [31:0] mregs [32];
    logic        mhalted;
    logic        last_stall;
    logic [31:0] pc4_cur;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [191:0] obs();
        return {19'd0, op, rs, rt, imm, dest_2_ex, wr_en_2_ex, valid_2_ex, pc4_out_2_ex, i_data_2_ex};
    endfunction

    function automatic bit m_rtype(input int o);   return (o <= 10) && (o % 2 == 0); endfunction
    function automatic bit m_itype(input int o);   return ((o <= 11) && (o % 2 == 1)) || (o == 12); endfunction
    function automatic bit m_needs_a(input int o); return o <= 16; endfunction
    function automatic bit m_needs_b(input int o); return m_rtype(o) || (o == 13) || (o == 15); endfunction

    function automatic logic [31:0] m_read(input int r, input rec_t w);
        if (r == 0) return 32'd0;
        if (w.wr && (w.dest == r)) return w.data;
        return mregs[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        pipe.delete();
        mhalted    = 1'b0;
        last_stall = 1'b0;
    endtask

    // One pipeline cycle: drive at negedge, check stall, check bundle after posedge
    task automatic step(input logic [31:0] ins, input logic iv, input logic fl, input logic [31:0] wbv);
        rec_t         w;
        rec_t         nr;
        int           o, a, b, d;
        bit           haz, issue, wr, exp_stall;
        logic [191:0] eb;
        @(negedge clk);
        i_data   = ins;
        pc4_in   = pc4_cur;
        if_valid = iv;
        flush    = fl;
        w.wr = 1'b0; w.dest = 5'd0; w.data = 32'd0;
        if (pipe.size() >= 3) w = pipe[2];
        wb_we   = w.wr;
        wb_addr = w.dest;
        wb_data = w.data;
        o = int'(ins[31:26]);
        a = int'(ins[25:21]);
        b = int'(ins[20:16]);
        haz = 1'b0;
        for (int i = 0; i < 2 && i < pipe.size(); i++) begin
            if (pipe[i].wr && ((m_needs_a(o) && a != 0 && pipe[i].dest == a) ||
                               (m_needs_b(o) && b != 0 && pipe[i].dest == b)))
                haz = 1'b1;
        end
        exp_stall = mhalted || (iv && !fl && haz);
        issue     = iv && !fl && !mhalted && !haz && (o <= 17);
        d  = m_rtype(o) ? int'(ins[15:11]) : (m_itype(o) ? b : 0);
        wr = issue && (m_rtype(o) || m_itype(o)) && (d != 0);
        eb = '0;
        if (issue)
            eb = {19'd0, ins[31:26], m_read(a, w), m_read(b, w), {{16{ins[15]}}, ins[15:0]},
                  wr ? 5'(d) : 5'd0, wr, 1'b1, pc4_cur, ins};
        #1;
        chk("id_stall", id_stall, exp_stall);
        if (w.wr) mregs[w.dest] = w.data;
        if (issue && o == 17) mhalted = 1'b1;
        nr.wr = wr; nr.dest = wr ? 5'(d) : 5'd0; nr.data = wbv;
        pipe.push_front(nr);
        if (pipe.size() > 3) void'(pipe.pop_back());
        last_stall = exp_stall;
        @(posedge clk);
        #1;
        chk("bundle", obs(), eb);
        chk("halted", halted, mhalted);
    endtask

    // Asynchronous reset mid-cycle, checked before the next clock edge
    task automatic do_reset();
        #2;
        rst      = 1'b1;
        if_valid = 1'b0;
        flush    = 1'b0;
        wb_we    = 1'b0;
        #1;
        chk("rst_bundle", obs(), 192'd0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_stall", id_stall, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic issue_until(input logic [31:0] ins, output int stalls);
        stalls = 0;
        pc4_cur += 4;
        for (int k = 0; k < 8; k++) begin
            step(ins, 1'b1, 1'b0, $urandom);
            if (last_stall) stalls++;
            else break;
        end
    endtask

    function automatic logic [31:0] rins(input int o, input int a, input int b, input int c);
        return {6'(o), 5'(a), 5'(b), 5'(c), 11'd0};
    endfunction

    function automatic logic [31:0] iins(input int o, input int a, input int b, input logic [15:0] v);
        return {6'(o), 5'(a), 5'(b), v};
    endfunction

    initial begin
        int          st;
        int          hcnt;
        int          o;
        logic [31:0] cur;
        rst = 1'b1; i_data = '0; pc4_in = '0; if_valid = 1'b0; flush = 1'b0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0; pc4_cur = 32'h100;
        model_reset();
        #12;
        chk("reset_bundle", obs(), 192'd0);
        chk("reset_halted", halted, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // ADDI R1,R0,10; WB later returns 0xA
        pc4_cur += 4;
        step(32'h0401000A, 1'b1, 1'b0, 32'h0000000A);
        chk("addi_op", op, 6'h01);
        chk("addi_rs", rs, 32'd0);
        chk("addi_imm", imm, 32'h0000000A);
        chk("addi_dest", dest_2_ex, 5'd1);
        chk("addi_wr", wr_en_2_ex, 1'b1);
        chk("addi_valid", valid_2_ex, 1'b1);

        // ADD R3,R1,R2 right behind its producer
        issue_until(rins(0, 1, 2, 3), st);
        chk("raw_stalls", st, 2);
        chk("raw_bypass_rs", rs, 32'h0000000A);

        // SUBI R2,R1,-11
        issue_until(iins(3, 1, 2, 16'hFFF5), st);
        chk("subi_imm", imm, 32'hFFFFFFF5);
        chk("subi_dest", dest_2_ex, 5'd2);

        // ADD R0,R4,R5 then ADD R6,R0,R0
        issue_until(rins(0, 4, 5, 0), st);
        chk("r0_dest_wr", wr_en_2_ex, 1'b0);
        issue_until(rins(0, 0, 0, 6), st);
        chk("r0_src_stalls", st, 0);
        chk("r0_src_rs", rs, 32'd0);
        chk("r0_src_rt", rt, 32'd0);

        // Flush a stalled BEQ; the producer must still be tracked afterwards
        issue_until(iins(1, 0, 7, 16'h0005), st);
        pc4_cur += 4;
        step(iins(15, 7, 7, 16'h0004), 1'b1, 1'b1, 32'd0);
        chk("flush_valid", valid_2_ex, 1'b0);
        issue_until(rins(0, 7, 0, 8), st);
        chk("post_flush_stalls", st, 1);

        // HALT then ADD
        issue_until(32'h44000000, st);
        chk("halt_valid", valid_2_ex, 1'b1);
        chk("halt_op", op, 6'h11);
        chk("halt_sticky", halted, 1'b1);
        pc4_cur += 4;
        for (int k = 0; k < 3; k++) begin
            step(rins(0, 1, 1, 9), 1'b1, 1'b0, 32'd0);
            chk("halted_bubble", valid_2_ex, 1'b0);
        end
        do_reset();

        // Reset in the middle of a stall
        issue_until(32'h0401000A, st);
        pc4_cur += 4;
        step(rins(0, 1, 0, 3), 1'b1, 1'b0, 32'd0);
        do_reset();
        issue_until(rins(0, 1, 0, 3), st);
        chk("post_rst_stalls", st, 0);

        // Randomized traffic, small register range to provoke hazards
        cur  = 32'd0;
        hcnt = 0;
        for (int n = 0; n < 700; n++) begin
            if (mhalted) begin
                hcnt++;
                if (hcnt > 3) begin
                    do_reset();
                    hcnt = 0;
                end
            end else if ($urandom_range(0, 150) == 0) begin
                do_reset();
            end
            if (!last_stall || mhalted) begin
                if ($urandom_range(0, 80) == 0) o = 17;
                else if ($urandom_range(0, 9) == 0) o = $urandom_range(18, 63);
                else o = $urandom_range(0, 16);
                cur = {6'(o), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 11'($urandom)};
                pc4_cur += 4;
            end
            step(cur, ($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
